mem_access_stage: RTL

//  Memory-access stage directly downstream of the integer ALU in the 5-stage pipeline.
//  It consumes the ALU result as a load/store address, or as the pass-through value for non-memory ops.
//  It drives the data-memory valid/ready request channel and size-aligns/sign-extends load data.
//  It issues one single-cycle result pulse to writeback and holds the upstream pipeline while busy.

---
 rtl/mem_access_stage.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/mem_access_stage.sv
// -----------------------------------------------------------------------------
// mem_access_stage
//
// Memory-access stage that sits directly after the integer ALU. It takes one
// op at a time. For loads/stores the ALU result is the byte address: the stage
// drives a valid/ready request to data memory, waits for the read response on
// loads, and size-aligns / extends the returned data. Non-memory ops simply
// pass the ALU result through. Each op finishes with exactly one out_valid
// pulse. in_ready is low whenever an op is in flight.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   in_valid / in_ready   upstream handshake (in_ready = stage idle)
//   is_load, is_store     op kind (both set = illegal)
//   funct3                000 B, 001 H, 010 W, 100 BU, 101 HU
//   alu_result            byte address (mem ops) or result value
//   store_data            store source (rs2)
//   rd_in                 destination register
//   mem_req_*             data-memory request channel (word address, lanes)
//   mem_rsp_valid/rdata   single-cycle read response
//   out_valid/rd/data     one-cycle writeback pulse, held between pulses
//   out_fault             misalignment / illegal funct3 / response timeout
//
// Parameter
//   RSP_TIMEOUT           cycles allowed in WAIT_RSP before faulting; 0 = off
// -----------------------------------------------------------------------------
module mem_access_stage #(
    parameter int unsigned RSP_TIMEOUT = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        is_load,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] alu_result,
    input  logic [31:0] store_data,
    input  logic [4:0]  rd_in,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic        mem_req_we,
    output logic [31:0] mem_req_addr,
    output logic [31:0] mem_req_wdata,
    output logic [3:0]  mem_req_wstrb,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_rdata,
    output logic        out_valid,
    output logic [4:0]  out_rd,
    output logic [31:0] out_data,
    output logic        out_fault
);

    localparam int unsigned CW = (RSP_TIMEOUT < 2) ? 1 : $clog2(RSP_TIMEOUT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(RSP_TIMEOUT);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PASS     = 3'd1,
        REQ      = 3'd2,
        WAIT_RSP = 3'd3,
        DONE     = 3'd4
    } state_t;

    state_t state_reg, state_next;

    // Per-op context captured at accept time
    logic [2:0]    funct3_reg;
    logic [1:0]    off_reg;
    logic [4:0]    rd_reg;
    logic [31:0]   result_reg;
    logic          fault_reg;
    logic [CW-1:0] cnt_reg;

    // Accept-time decode
    logic accept;
    logic mem_op;
    logic bad_f3;
    logic misalign;
    logic op_fault;

    assign in_ready      = (state_reg == IDLE);
    assign mem_req_valid = (state_reg == REQ);
    assign accept        = in_valid && in_ready;
    assign mem_op        = is_load || is_store;

    always_comb begin
        bad_f3   = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
        misalign = ((funct3[1:0] == 2'b01) && alu_result[0]) ||
                   ((funct3[1:0] == 2'b10) && (alu_result[1:0] != 2'b00));
        // Only memory ops can fault; ALU ops reuse funct3 for other purposes.
        op_fault = mem_op && (bad_f3 || misalign || (is_load && is_store));
    end

    // Store lane steering: each byte lane picks its source byte and enable.
    logic [31:0] lane_wdata;
    logic [3:0]  lane_wstrb;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            localparam logic [1:0] LANE = 2'(gi);
            assign lane_wdata[8*gi +: 8] =
                (funct3[1:0] == 2'b10) ? store_data[8*gi +: 8] :
                (funct3[1:0] == 2'b01) ? store_data[8*(gi%2) +: 8] :
                                         store_data[7:0];
            assign lane_wstrb[gi] =
                (funct3[1:0] == 2'b10) ? 1'b1 :
                (funct3[1:0] == 2'b01) ? (alu_result[1] == LANE[1]) :
                                         (alu_result[1:0] == LANE);
        end
    endgenerate

    // Load extraction from the returned word
    logic [31:0] shifted;
    logic [31:0] load_data;

    always_comb begin
        shifted = mem_rsp_rdata >> {off_reg, 3'b000};
        case (funct3_reg)
            3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  load_data = {24'd0, shifted[7:0]};
            3'b101:  load_data = {16'd0, shifted[15:0]};
            default: load_data = mem_rsp_rdata;
        endcase
    end

    // Counter value after this cycle equals the limit -> give up.
    // A response in the same cycle takes priority.
    logic timeout_hit;
    assign timeout_hit = (RSP_TIMEOUT != 0) && !mem_rsp_valid &&
                         ((cnt_reg + CW'(1)) == LIMIT);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next = (mem_op && !op_fault) ? REQ : PASS;
                end
            end
            PASS: state_next = IDLE;
            REQ: begin
                if (mem_req_ready) begin
                    state_next = mem_req_we ? DONE : WAIT_RSP;
                end
            end
            WAIT_RSP: begin
                if (mem_rsp_valid || timeout_hit) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            funct3_reg    <= 3'd0;
            off_reg       <= 2'd0;
            rd_reg        <= 5'd0;
            result_reg    <= 32'd0;
            fault_reg     <= 1'b0;
            cnt_reg       <= '0;
            mem_req_we    <= 1'b0;
            mem_req_addr  <= 32'd0;
            mem_req_wdata <= 32'd0;
            mem_req_wstrb <= 4'd0;
            out_valid     <= 1'b0;
            out_rd        <= 5'd0;
            out_data      <= 32'd0;
            out_fault     <= 1'b0;
        end else begin
            out_valid <= 1'b0;

            if (accept) begin
                funct3_reg <= funct3;
                off_reg    <= alu_result[1:0];
                rd_reg     <= rd_in;
                result_reg <= mem_op ? 32'd0 : alu_result;
                fault_reg  <= op_fault;
                if (mem_op && !op_fault) begin
                    mem_req_we    <= is_store;
                    mem_req_addr  <= {alu_result[31:2], 2'b00};
                    mem_req_wdata <= is_store ? lane_wdata : 32'd0;
                    mem_req_wstrb <= is_store ? lane_wstrb : 4'd0;
                end
            end

            // Counter is held at zero outside WAIT_RSP so it is clear on entry.
            if (state_reg != WAIT_RSP) begin
                cnt_reg <= '0;
            end else if (!mem_rsp_valid) begin
                cnt_reg <= cnt_reg + CW'(1);
            end

            if (state_reg == WAIT_RSP) begin
                if (mem_rsp_valid) begin
                    result_reg <= load_data;
                end else if (timeout_hit) begin
                    fault_reg <= 1'b1;
                end
            end

            // Outputs only change together with the pulse.
            if ((state_reg == PASS) || (state_reg == DONE)) begin
                out_valid <= 1'b1;
                out_rd    <= rd_reg;
                out_data  <= result_reg;
                out_fault <= fault_reg;
            end
        end
    end

endmodule
